// File: rtl/gpio_ctrl.sv
// Purpose : GPIO peripheral with 2-flop synchronised, debounced inputs, sticky edge flags with a
//           maskable level interrupt, a core-writable LED output latch and a programmable tick strobe.
// Latency : input change to IN register is 2+DEB_CYCLES clocks; register writes land on the write edge;
//           rdata is combinational from addr. There is no backpressure: every write is accepted at once.
//
// Ports:
//   clk     - system clock; all state changes on its rising edge
//   rst     - asynchronous reset, active low (0 = reset)
//   gpio_i  - raw asynchronous inputs (switches), IN_W bits
//   gpio_o  - output latch (LEDs), OUT_W bits
//   addr    - register word index: 0 IN, 1 OUT, 2 EDGE, 3 MASK, 4 DIV, 5..7 reserved
//   we      - write strobe, sampled on clk
//   wdata   - write data
//   rdata   - read data, combinational from addr; unused bits read 0
//   irq_o   - level interrupt: OR of (EDGE & MASK)
//   tick_o  - registered one-cycle enable strobe, once every div+1 cycles

module gpio_ctrl #(
    parameter int unsigned       IN_W         = 9,
    parameter int unsigned       OUT_W        = 9,
    parameter int unsigned       DEB_CYCLES   = 4,
    parameter int unsigned       DIV_W        = 26,
    parameter logic [DIV_W-1:0]  TICK_DIV_RST = DIV_W'(49999999),
    parameter logic [OUT_W-1:0]  OUT_RST      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  gpio_i,
    output logic [OUT_W-1:0] gpio_o,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq_o,
    output logic             tick_o
);

    // Debounce counter only has to reach DEB_CYCLES-1.
    localparam int unsigned      CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [2:0] A_IN   = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_MASK = 3'd3;
    localparam logic [2:0] A_DIV  = 3'd4;

    // ------------------------------------------------------------------
    // Input synchroniser and debounce
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  meta;
    logic [IN_W-1:0]  sync;
    logic [IN_W-1:0]  stable;
    logic [CNT_W-1:0] deb_cnt [IN_W];

    logic [IN_W-1:0]  accept;
    logic [IN_W-1:0]  rise_set;
    logic [IN_W-1:0]  fall_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= gpio_i;
            sync <= meta;
        end
    end

    // A bit is accepted on the edge where it has disagreed with stable for
    // DEB_CYCLES consecutive samples; any agreement in between restarts the count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < IN_W; i++) begin
            accept[i] = (sync[i] != stable[i]) && (deb_cnt[i] == CNT_LAST);
        end
        rise_set = accept & sync;
        fall_set = accept & ~sync;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < IN_W; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (sync[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i]  <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    logic wr_out;
    logic wr_edge;
    logic wr_mask;
    logic wr_div;

    assign wr_out  = we && (addr == A_OUT);
    assign wr_edge = we && (addr == A_EDGE);
    assign wr_mask = we && (addr == A_MASK);
    assign wr_div  = we && (addr == A_DIV);

    // Not every write-data bit maps to storage for every parameter set.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // ------------------------------------------------------------------
    // Output latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_o <= OUT_RST;
        end else if (wr_out) begin
            gpio_o <= wdata[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sticky edge flags and interrupt mask
    // ------------------------------------------------------------------
    logic [IN_W-1:0] rise;
    logic [IN_W-1:0] fall;
    logic [IN_W-1:0] mask_rise;
    logic [IN_W-1:0] mask_fall;
    logic [IN_W-1:0] rise_clr;
    logic [IN_W-1:0] fall_clr;

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        if (wr_edge) begin
            rise_clr = wdata[IN_W-1:0];
            fall_clr = wdata[16 +: IN_W];
        end
    end

    // Set is OR-ed in after the clear so a new edge wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_rise <= '0;
            mask_fall <= '0;
        end else if (wr_mask) begin
            mask_rise <= wdata[IN_W-1:0];
            mask_fall <= wdata[16 +: IN_W];
        end
    end

    // Straight from flops: drops the cycle after the last enabled flag goes away.
    assign irq_o = |((rise & mask_rise) | (fall & mask_fall));

    // ------------------------------------------------------------------
    // Tick generator (clock-enable strobe)
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] tick_cnt;

    // Counter walks 0..div; the strobe is registered on the wrap so it is high
    // for exactly one cycle per div+1. div=0 wraps every cycle, holding tick_o high.
    // A divisor write restarts the period and suppresses the strobe that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div      <= TICK_DIV_RST;
            tick_cnt <= '0;
            tick_o   <= 1'b0;
        end else if (wr_div) begin
            div      <= wdata[DIV_W-1:0];
            tick_cnt <= '0;
            tick_o   <= 1'b0;
        end else if (tick_cnt == div) begin
            tick_cnt <= '0;
            tick_o   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick_o   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (addr)
            A_IN: begin
                rdata[IN_W-1:0] = stable;
            end
            A_OUT: begin
                rdata[OUT_W-1:0] = gpio_o;
            end
            A_EDGE: begin
                rdata[IN_W-1:0]  = rise;
                rdata[16 +: IN_W] = fall;
            end
            A_MASK: begin
                rdata[IN_W-1:0]  = mask_rise;
                rdata[16 +: IN_W] = mask_fall;
            end
            A_DIV: begin
                rdata[DIV_W-1:0] = div;
            end
            default: begin
                rdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Purpose : self-checking bench for gpio_ctrl with a window-based behavioural model and directed vectors.
// Latency : model is updated on every rising edge; outputs compared 1 time unit after each rising edge.
// Inputs  : driven on falling edges; no backpressure involved.

module tb_gpio_ctrl;

    localparam int IN_W  = 9;
    localparam int OUT_W = 9;
    localparam int DEB   = 4;
    localparam int DIV_W = 26;

    logic             clk;
    logic             rst;
    logic [IN_W-1:0]  gpio_i;
    logic [OUT_W-1:0] gpio_o;
    logic [2:0]       addr;
    logic             we;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             irq_o;
    logic             tick_o;

    int total = 0;
    int bad   = 0;

    gpio_ctrl #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEB_CYCLES(DEB), .DIV_W(DIV_W),
        .TICK_DIV_RST(26'd49999999), .OUT_RST(9'd0)
    ) dut (
        .clk(clk), .rst(rst), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
        .irq_o(irq_o), .tick_o(tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: inputs are delayed two samples, a bit is accepted
    // once the last DEB samples all agree on a value different from the
    // accepted one; tick fires whenever the cycles since restart is a
    // positive multiple of div+1.
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  m_s1, m_s2, m_stable, m_rise, m_fall, m_mrise, m_mfall;
    logic [IN_W-1:0]  m_hist [DEB];
    logic [OUT_W-1:0] m_out;
    logic [DIV_W-1:0] m_div;
    longint           m_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_mrise = '0; m_mfall = '0;
            for (int k = 0; k < DEB; k++) m_hist[k] = '0;
            m_out = '0;
            m_div = 26'd49999999;
            m_t   = 0;
        end else begin : step
            logic [IN_W-1:0] nst;
            logic            same;
            for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            nst = m_stable;
            for (int b = 0; b < IN_W; b++) begin
                same = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (m_hist[k][b] !== m_hist[0][b]) same = 1'b0;
                if (same && (m_hist[0][b] !== m_stable[b])) nst[b] = m_hist[0][b];
            end
            m_t = m_t + 1;
            if (we) begin
                case (addr)
                    3'd1: m_out = wdata[OUT_W-1:0];
                    3'd2: begin
                        m_rise = m_rise & ~wdata[IN_W-1:0];
                        m_fall = m_fall & ~wdata[16 +: IN_W];
                    end
                    3'd3: begin
                        m_mrise = wdata[IN_W-1:0];
                        m_mfall = wdata[16 +: IN_W];
                    end
                    3'd4: begin
                        m_div = wdata[DIV_W-1:0];
                        m_t   = 0;
                    end
                    default: ;
                endcase
            end
            m_rise   = m_rise | (nst & ~m_stable);
            m_fall   = m_fall | (~nst & m_stable);
            m_stable = nst;
            m_s2     = m_s1;
            m_s1     = gpio_i;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[IN_W-1:0] = m_stable;
            3'd1: r[OUT_W-1:0] = m_out;
            3'd2: begin r[IN_W-1:0] = m_rise;  r[16 +: IN_W] = m_fall;  end
            3'd3: begin r[IN_W-1:0] = m_mrise; r[16 +: IN_W] = m_mfall; end
            3'd4: r[DIV_W-1:0] = m_div;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic exp_tick();
        return (m_t > 0) && ((m_t % (longint'(m_div) + 1)) == 0);
    endfunction

    always @(posedge clk) begin
        #1;
        chk("cyc_gpio_o", 32'(gpio_o), 32'(m_out));
        chk("cyc_irq", 32'(irq_o), 32'(|((m_rise & m_mrise) | (m_fall & m_mfall))));
        chk("cyc_tick", 32'(tick_o), 32'(exp_tick()));
        chk("cyc_rdata", rdata, exp_rdata(addr));
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0; gpio_i = 9'h1FF; we = 1'b0; addr = 3'd0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_tick", 32'(tick_o), 32'h0);
        chk("rst_in", rdata, 32'h0);

        // Release: IN must become 1FF exactly 6 clocks later.
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("in_lat5", rdata, 32'h0);
        @(negedge clk);
        chk("in_lat6", rdata, 32'h1FF);

        gpio_i = 9'h000;
        repeat (10) @(negedge clk);
        wr(3'd2, 32'hFFFF_FFFF);

        // 3-cycle glitch is rejected.
        gpio_i = 9'h001; repeat (3) @(negedge clk);
        gpio_i = 9'h000; repeat (10) @(negedge clk);
        addr = 3'd0; #1 chk("glitch_in", rdata, 32'h0);
        addr = 3'd2; #1 chk("glitch_edge", rdata, 32'h0);

        // 4-cycle pulse is accepted both ways.
        @(negedge clk);
        gpio_i = 9'h001; repeat (4) @(negedge clk);
        gpio_i = 9'h000; repeat (10) @(negedge clk);
        chk("pulse4_edge", rdata, 32'h0001_0001);
        wr(3'd2, 32'hFFFF_FFFF);

        // Interrupt on fall of bit 0 only.
        wr(3'd3, 32'h0001_0000);
        gpio_i = 9'h001; repeat (8) @(negedge clk);
        addr = 3'd0; #1 chk("hold_in", rdata, 32'h1);
        addr = 3'd2; #1 chk("hold_rise", rdata, 32'h1);
        chk("irq_after_rise", 32'(irq_o), 32'h0);
        gpio_i = 9'h000; repeat (8) @(negedge clk);
        chk("irq_after_fall", 32'(irq_o), 32'h1);
        chk("edge_both", rdata, 32'h0001_0001);
        wr(3'd2, 32'h0001_0000);
        chk("irq_cleared", 32'(irq_o), 32'h0);
        chk("rise_kept", rdata, 32'h1);

        // W1C of bit 2 lands on the same edge stable[2] rises: set wins.
        gpio_i = 9'h004; repeat (5) @(negedge clk);
        #1 chk("w1c_pre", rdata, 32'h1);
        wr(3'd2, 32'h4);
        chk("w1c_set_wins", rdata, 32'h5);

        // Output latch.
        wr(3'd1, 32'hFFFF_F0A5);
        chk("out_pins", 32'(gpio_o), 32'h0A5);
        chk("out_read", rdata, 32'h0000_00A5);

        // Reserved address.
        wr(3'd5, 32'hFFFF_FFFF);
        chk("rsvd_read", rdata, 32'h0);

        // Tick, period 4.
        wr(3'd4, 32'd3);
        chk("div_read", rdata, 32'd3);
        chk("tick_k0", 32'(tick_o), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("tick_div3", 32'(tick_o), 32'((k % 4) == 0));
        end
        // Restart mid-period.
        repeat (2) @(negedge clk);
        wr(3'd4, 32'd3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("tick_restart", 32'(tick_o), 32'(k == 4));
        end
        // div = 0: continuous after the write cycle.
        wr(3'd4, 32'd0);
        chk("tick0_wr", 32'(tick_o), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("tick0_cont", 32'(tick_o), 32'h1);
        end

        // Asynchronous reset mid-operation.
        addr = 3'd1;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_out", 32'(gpio_o), 32'h0);
        chk("mid_rst_read", rdata, 32'h0);
        chk("mid_rst_tick", 32'(tick_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        addr = 3'd0;
        repeat (5) @(negedge clk);
        chk("resync5", rdata, 32'h0);
        @(negedge clk);
        chk("resync6", rdata, 32'h4);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised GPIO peripheral that replaces direct switch-to-core and ALU-to-LED wiring on the board top level. Inputs are synchronised and debounced per bit, with sticky rise/fall edge flags and a maskable interrupt. A core-writable output latch drives the LEDs. A programmable tick generator produces a single-cycle enable strobe, replacing the ripple-carry clock divider with a clock-enable scheme.

Parameters:
IN_W, 9, input channel count (1..16)
OUT_W, 9, output channel count (1..32)
DEB_CYCLES, 4, consecutive stable cycles required before a synchronised input is accepted (>=1)
DIV_W, 26, tick divider width
TICK_DIV_RST, 49999999, reset value of tick divisor
OUT_RST, 0, reset value of output latch

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
gpio_i  in  IN_W  raw asynchronous inputs (switches)
gpio_o  out  OUT_W  output latch (LEDs)
addr  in  3  register address
we  in  1  write strobe, sampled on clk
wdata  in  32  write data
rdata  out  32  read data, combinational from addr
irq_o  out  1  interrupt, level
tick_o  out  1  one-cycle enable strobe

Behaviour:
- Reset (rst=0, asynchronous) sets: sync regs 0, stable 0, debounce counters 0, edge flags 0, mask 0, gpio_o=OUT_RST, div=TICK_DIV_RST, tick counter 0, tick_o=0, irq_o=0.
- Synchroniser: 2 flip-flops per bit. sync = second stage.
- Debounce, per bit:
  - if sync==stable: cnt<=0.
  - else if cnt==DEB_CYCLES-1: stable<=sync, cnt<=0.
  - else: cnt<=cnt+1.
  - A glitch shorter than DEB_CYCLES cycles at sync never changes stable.
  - Latency from a gpio_i change to a stable change is 2+DEB_CYCLES clocks.
- Edges: when stable bit i goes 0->1, rise[i]<=1; when it goes 1->0, fall[i]<=1. Flags are sticky.
- Register map (word index in addr):
  - 0 IN: RO, rdata[IN_W-1:0]=stable.
  - 1 OUT: RW, write loads gpio_o<=wdata[OUT_W-1:0]; read returns gpio_o.
  - 2 EDGE: rise in [IN_W-1:0], fall in [16+IN_W-1:16]. Write-1-to-clear.
  - 3 MASK: RW, same bit layout as EDGE.
  - 4 DIV: RW, DIV_W bits.
  - 5..7: read 0, writes ignored.
  - All unused rdata bits read 0.
  - Writes take effect at the clock edge where we=1; reading the same address in the next cycle returns the new value.
- Simultaneous W1C of a flag and a new edge on that same flag in one cycle: set wins, flag stays 1.
- irq_o = OR(EDGE & MASK), driven from registers with no extra latency. It deasserts the cycle after the last enabled flag is cleared or masked.
- Tick generator:
  - counter counts 0..div; tick_o is registered and is 1 for exactly one cycle per period, period = div+1 cycles.
  - div=0: tick_o stays 1 continuously.
  - A write to DIV loads the new divisor, resets the counter to 0 and forces tick_o=0 that cycle. The first tick then follows div+1 cycles later.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk. Stable resynchronises from 0 after reset release.

Test Plan:
- Reset: rst=0 with gpio_i=9'h1FF -> gpio_o=0, irq_o=0, tick_o=0, IN reads 0. After release, IN reads 9'h1FF exactly 2+4=6 clocks later (DEB_CYCLES=4).
- Debounce: 3-cycle pulse on gpio_i[0] -> IN unchanged, EDGE=0. A 4-cycle-or-longer hold -> IN[0]=1 and EDGE bit0 (rise) set.
- Edge/IRQ: MASK=32'h0001_0000, then toggle gpio_i[0] 0->1->0 -> rise0 and fall0 both set, irq_o=1 only after the fall. Write EDGE=32'h0001_0000 -> irq_o=0 next cycle, rise0 still reads 1.
- W1C vs. new edge: in the same cycle that stable[2] rises, write EDGE=32'h4 -> bit2 reads 1 afterwards.
- OUT: write addr1 wdata=32'hFFFF_F0A5 -> gpio_o=9'h0A5 next cycle; read of addr1 returns 32'h0000_00A5.
- Tick: write DIV=3 -> tick_o pulses every 4 cycles, first pulse 4 cycles after the write. DIV=0 -> tick_o=1 every cycle. Rewriting DIV mid-period restarts the count.
